cu_sequencer: RTL and testbench

//  Top-level control sequencer. Sits directly upstream of the per-class control units (immediate, register,

---
 rtl/cu_sequencer.sv | 152 +++++++++++++++
 tb/tb_cu_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer.sv
// Top-level control sequencer: fetches and classifies instructions, then routes
// the active sub-CU's control word and next state while owning IR, state and NZCV.
module cu_sequencer #(
  parameter int              CUL      = 35,
  parameter logic [CUL:0]    FETCH_CW = 36'h000000200,
  parameter int              MAX_EX   = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [31:0]    imem_data,
  input  logic           imem_ready,
  input  logic [3:0]     alu_status,
  input  logic [CUL:0]   cw_imm,
  input  logic [CUL:0]   cw_reg,
  input  logic [CUL:0]   cw_mem,
  input  logic [CUL:0]   cw_br,
  input  logic [3:0]     ns_imm,
  input  logic [3:0]     ns_reg,
  input  logic [3:0]     ns_mem,
  input  logic [3:0]     ns_br,
  input  logic [2:0]     km_imm,
  input  logic [2:0]     km_reg,
  input  logic [2:0]     km_mem,
  input  logic [2:0]     km_br,
  output logic [31:0]    IR,
  output logic [3:0]     state,
  output logic [3:0]     status,
  output logic [CUL:0]   controlWord,
  output logic [2:0]     k_mux,
  output logic           halted,
  output logic [1:0]     err_code
);

  typedef enum logic [1:0] {
    PH_FETCH = 2'b00,
    PH_EXEC  = 2'b01,
    PH_HALT  = 2'b10
  } phase_t;

  phase_t       phase_reg, phase_next;
  logic [31:0]  ir_reg, ir_next;
  logic [3:0]   state_reg, state_next;
  logic [3:0]   status_reg, status_next;
  logic [3:0]   ex_cnt_reg, ex_cnt_next;
  logic [1:0]   err_reg, err_next;

  logic [CUL:0] sel_cw;
  logic [3:0]   sel_ns;
  logic [2:0]   sel_km;
  logic         legal;
  logic [CUL:0] cw_out;
  logic [2:0]   km_out;

  // Class decode on the held IR; earlier branches take priority.
  always_comb begin
    sel_cw = '0;
    sel_ns = '0;
    sel_km = '0;
    legal  = 1'b1;
    if (ir_reg[28:26] == 3'b100) begin
      sel_cw = cw_imm; sel_ns = ns_imm; sel_km = km_imm;
    end else if (ir_reg[28:26] == 3'b101) begin
      sel_cw = cw_br;  sel_ns = ns_br;  sel_km = km_br;
    end else if (ir_reg[27] && !ir_reg[25]) begin
      sel_cw = cw_mem; sel_ns = ns_mem; sel_km = km_mem;
    end else if (ir_reg[27:25] == 3'b101) begin
      sel_cw = cw_reg; sel_ns = ns_reg; sel_km = km_reg;
    end else begin
      legal = 1'b0;
    end
  end

  always_comb begin
    phase_next  = phase_reg;
    ir_next     = ir_reg;
    state_next  = state_reg;
    status_next = status_reg;
    ex_cnt_next = ex_cnt_reg;
    err_next    = err_reg;
    cw_out      = '0;
    km_out      = '0;
    case (phase_reg)
      PH_FETCH: begin
        cw_out = FETCH_CW;
        if (imem_ready) begin
          ir_next     = imem_data;
          state_next  = 4'b0001;
          ex_cnt_next = 4'd1;
          phase_next  = PH_EXEC;
        end
      end
      PH_EXEC: begin
        if (legal) begin
          cw_out = sel_cw;
          km_out = sel_km;
          // bit 8 of the control word is the status-load strobe
          if (sel_cw[8]) status_next = alu_status;
          if (sel_ns == 4'b0000) begin
            phase_next  = PH_FETCH;
            state_next  = 4'b0000;
            ex_cnt_next = 4'd0;
          end else if (ex_cnt_reg == 4'(MAX_EX)) begin
            phase_next = PH_HALT;
            state_next = 4'b0000;
            err_next   = 2'b10;
          end else begin
            state_next  = sel_ns;
            ex_cnt_next = ex_cnt_reg + 4'd1;
          end
        end else begin
          phase_next = PH_HALT;
          state_next = 4'b0000;
          err_next   = 2'b01;
        end
      end
      PH_HALT: begin
        phase_next = PH_HALT;
      end
      default: begin
        phase_next = PH_FETCH;
        state_next = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_reg  <= PH_FETCH;
      ir_reg     <= '0;
      state_reg  <= '0;
      status_reg <= '0;
      ex_cnt_reg <= '0;
      err_reg    <= '0;
    end else begin
      phase_reg  <= phase_next;
      ir_reg     <= ir_next;
      state_reg  <= state_next;
      status_reg <= status_next;
      ex_cnt_reg <= ex_cnt_next;
      err_reg    <= err_next;
    end
  end

  assign IR          = ir_reg;
  assign state       = state_reg;
  assign status      = status_reg;
  assign controlWord = cw_out;
  assign k_mux       = km_out;
  assign halted      = (phase_reg == PH_HALT);
  assign err_code    = err_reg;

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed scenarios followed by random
// stimulus, every cycle compared against an instruction-level reference model.
module tb_cu_sequencer;
  localparam logic [35:0] FETCH_CW = 36'h000000200;
  localparam int          MAX_EX   = 8;
  localparam logic [31:0] ADDI     = 32'h1100_0000;
  localparam logic [31:0] REGOP    = 32'h0A00_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic [3:0]  alu_status;
  logic [35:0] cw_a [4];   // 0 imm, 1 br, 2 mem, 3 reg
  logic [3:0]  ns_a [4];
  logic [2:0]  km_a [4];
  logic [31:0] IR;
  logic [3:0]  state;
  logic [3:0]  status;
  logic [35:0] controlWord;
  logic [2:0]  k_mux;
  logic        halted;
  logic [1:0]  err_code;

  cu_sequencer #(.CUL(35), .FETCH_CW(FETCH_CW), .MAX_EX(MAX_EX)) dut (
    .clock(clock), .reset(reset), .imem_data(imem_data), .imem_ready(imem_ready),
    .alu_status(alu_status),
    .cw_imm(cw_a[0]), .cw_reg(cw_a[3]), .cw_mem(cw_a[2]), .cw_br(cw_a[1]),
    .ns_imm(ns_a[0]), .ns_reg(ns_a[3]), .ns_mem(ns_a[2]), .ns_br(ns_a[1]),
    .km_imm(km_a[0]), .km_reg(km_a[3]), .km_mem(km_a[2]), .km_br(km_a[1]),
    .IR(IR), .state(state), .status(status), .controlWord(controlWord),
    .k_mux(k_mux), .halted(halted), .err_code(err_code)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: where we are in the instruction, not how the RTL encodes it.
  int          m_mode;     // 0 fetching, 1 executing, 2 halted
  logic [31:0] m_ir;
  int          m_state;
  logic [3:0]  m_status;
  int          m_cycles;   // EXEC cycles spent on the current instruction
  int          m_err;
  int          n_instr = 0;

  function automatic int klass(input logic [31:0] ir);
    int top3 = int'((ir >> 26) & 32'd7);
    int mid3 = int'((ir >> 25) & 32'd7);
    if (top3 == 4) return 0;
    if (top3 == 5) return 1;
    if (ir[27] && !ir[25]) return 2;
    if (mid3 == 5) return 3;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ir = '0; m_state = 0; m_status = '0; m_cycles = 0; m_err = 0;
  endtask

  task automatic model_step();
    int k;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (imem_ready) begin
        m_ir = imem_data; m_state = 1; m_cycles = 1; m_mode = 1;
        n_instr++;
        $display("[TB] instr %0d fetched ir=%08h class=%0d", n_instr, imem_data, klass(imem_data));
      end
    end else if (m_mode == 1) begin
      k = klass(m_ir);
      if (k < 0) begin
        m_mode = 2; m_err = 1; m_state = 0;
      end else begin
        if (cw_a[k][8]) m_status = alu_status;
        if (ns_a[k] == 4'd0) begin
          m_mode = 0; m_state = 0;
        end else if (m_cycles >= MAX_EX) begin
          m_mode = 2; m_err = 2; m_state = 0;
        end else begin
          m_state = int'(ns_a[k]); m_cycles++;
        end
      end
    end
  endtask

  function automatic logic [35:0] exp_cw();
    int k = klass(m_ir);
    if (m_mode == 0) return FETCH_CW;
    if (m_mode == 1 && k >= 0) return cw_a[k];
    return '0;
  endfunction

  function automatic logic [2:0] exp_km();
    int k = klass(m_ir);
    if (m_mode == 1 && k >= 0) return km_a[k];
    return 3'b000;
  endfunction

  // Called at a negedge with inputs already set: compare, then cross one rising edge.
  task automatic cycle();
    #1;
    check("state",  64'(state),       64'(m_state));
    check("cw",     64'(controlWord), 64'(exp_cw()));
    check("k_mux",  64'(k_mux),       64'(exp_km()));
    check("halted", 64'(halted),      64'(m_mode == 2));
    check("err",    64'(err_code),    64'(m_err));
    check("ir",     64'(IR),          64'(m_ir));
    check("status", 64'(status),      64'(m_status));
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic rand_subcu();
    for (int i = 0; i < 4; i++) begin
      cw_a[i] = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
      km_a[i] = 3'($urandom);
    end
  endtask

  task automatic zero_ns();
    for (int i = 0; i < 4; i++) ns_a[i] = 4'd0;
  endtask

  int zero_pct;
  int c;
  logic [31:0] d;

  initial begin
    model_reset();
    reset = 1'b1; imem_ready = 1'b0; imem_data = '0; alu_status = '0;
    rand_subcu(); zero_ns();
    @(negedge clock);
    cycle();   // reset held: reset values compared
    reset = 1'b0;

    // 1: single-cycle ADDI
    imem_ready = 1'b1; imem_data = ADDI;
    #1 check("t1_fetch_cw", 64'(controlWord), 64'(FETCH_CW));
    cycle();
    imem_ready = 1'b0;
    #1 check("t1_exec_state", 64'(state), 64'd1);
    check("t1_exec_cw", 64'(controlWord), 64'(cw_a[0]));
    cycle();
    #1 check("t1_back_fetch", 64'(controlWord), 64'(FETCH_CW));

    // 2: two-step immediate
    imem_ready = 1'b1; cycle();
    imem_ready = 1'b0; ns_a[0] = 4'b0010; cycle();
    ns_a[0] = 4'b0000;
    #1 check("t2_state2", 64'(state), 64'd2);
    cycle();
    #1 check("t2_fetch", 64'(state), 64'd0);
    check("t2_halted", 64'(halted), 64'd0);

    // 3: fetch stall
    imem_data = REGOP; imem_ready = 1'b0;
    repeat (5) cycle();
    #1 check("t3_ir_held", 64'(IR), 64'(ADDI));
    imem_ready = 1'b1; cycle();
    imem_ready = 1'b0; zero_ns(); cycle();

    // 4: status load on the final EXEC cycle, then suppressed
    imem_data = ADDI; imem_ready = 1'b1; cycle();
    imem_ready = 1'b0; cw_a[0][8] = 1'b1; alu_status = 4'b1001; cycle();
    #1 check("t4_status", 64'(status), 64'h9);
    imem_ready = 1'b1; cycle();
    imem_ready = 1'b0; cw_a[0][8] = 1'b0; alu_status = 4'b0110; cycle();
    #1 check("t4_status_kept", 64'(status), 64'h9);

    // 5: illegal opcode
    imem_data = 32'h0; imem_ready = 1'b1; cycle();
    imem_ready = 1'b0;
    #1 check("t5_cw_zero", 64'(controlWord), 64'd0);
    cycle();
    imem_data = ADDI;
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'(i % 2); cycle();
    end
    #1 check("t5_err", 64'(err_code), 64'd1);
    check("t5_halted", 64'(halted), 64'd1);

    // 6: EX timeout, then reset from HALT
    reset = 1'b1; cycle(); reset = 1'b0;
    imem_data = REGOP; imem_ready = 1'b1; cycle();
    imem_ready = 1'b0; ns_a[3] = 4'b0011;
    repeat (MAX_EX - 1) cycle();
    #1 check("t6_not_yet", 64'(halted), 64'd0);
    cycle();
    #1 check("t6_halted", 64'(halted), 64'd1);
    check("t6_err", 64'(err_code), 64'd2);
    reset = 1'b1; cycle(); reset = 1'b0;
    #1 check("t6_rst_err", 64'(err_code), 64'd0);
    check("t6_rst_halt", 64'(halted), 64'd0);
    check("t6_rst_cw", 64'(controlWord), 64'(FETCH_CW));

    // Random phase
    zero_pct = 60;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        c = int'($urandom_range(2));
        zero_pct = (c == 0) ? 60 : (c == 1) ? 20 : 0;
      end
      rand_subcu();
      for (int i = 0; i < 4; i++)
        ns_a[i] = (int'($urandom_range(99)) < zero_pct) ? 4'd0 : 4'($urandom_range(15, 1));
      d = $urandom;
      case ($urandom_range(4))
        1: d[28:26] = 3'b100;
        2: d[28:26] = 3'b101;
        3: begin d[27] = 1'b1; d[25] = 1'b0; end
        4: d[27:25] = 3'b101;
        default: ;
      endcase
      imem_data  = d;
      imem_ready = ($urandom_range(99) < 70);
      alu_status = 4'($urandom);
      reset = ($urandom_range(99) < 2) || (m_mode == 2 && $urandom_range(99) < 15);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
